// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, clog2 and byte-strobe merge for the register file
package regfile_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int MAX_WIDTH = 256;
  localparam int MAX_STRB = MAX_WIDTH / 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
  function automatic logic [MAX_WIDTH-1:0] byte_merge(
    input logic [MAX_WIDTH-1:0] old_w,
    input logic [MAX_WIDTH-1:0] new_w,
    input logic [MAX_STRB-1:0] strb
  );
    logic [MAX_WIDTH-1:0] r;
    for (int i = 0; i < MAX_STRB; i++) r[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: registered read port with write-first bypass and zero/out-of-range masking
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter bit ZERO_REG = 1'b0,
  localparam int ADDR = clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic [ADDR-1:0]    rd_addr,
  input  logic               wr_en,
  input  logic [ADDR-1:0]    wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_strb,
  input  logic [WIDTH-1:0]   mem [DEPTH],
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid
);
  logic addr_ok;
  logic hit;
  logic [WIDTH-1:0] old_w;
  logic [WIDTH-1:0] rd_next;
  always_comb begin
    addr_ok = (int'(rd_addr) < DEPTH) && !(ZERO_REG && (rd_addr == '0));
    hit = wr_en && (wr_addr == rd_addr);
    old_w = addr_ok ? mem[rd_addr] : '0;
    rd_next = !addr_ok ? '0
            : hit ? WIDTH'(byte_merge(MAX_WIDTH'(old_w), MAX_WIDTH'(wr_data), MAX_STRB'(wr_strb)))
            : old_w;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_next;
    end
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file, one strobed write port and two registered read ports
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter bit ZERO_REG = 1'b0,
  localparam int ADDR = clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WrEn,
  input  logic [ADDR-1:0]    WrAddr,
  input  logic [WIDTH-1:0]   WrData,
  input  logic [WIDTH/8-1:0] WrStrb,
  input  logic               RdEn_A,
  input  logic [ADDR-1:0]    RdAddr_A,
  output logic [WIDTH-1:0]   RdData_A,
  output logic               RdValid_A,
  input  logic               RdEn_B,
  input  logic [ADDR-1:0]    RdAddr_B,
  output logic [WIDTH-1:0]   RdData_B,
  output logic               RdValid_B
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic wr_ok;
  logic [WIDTH-1:0] wr_word;
  always_comb begin
    wr_ok = WrEn && (int'(WrAddr) < DEPTH) && !(ZERO_REG && (WrAddr == '0));
    wr_word = WIDTH'(byte_merge(MAX_WIDTH'(mem[WrAddr]), MAX_WIDTH'(WrData), MAX_STRB'(WrStrb)));
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[WrAddr] <= wr_word;
    end
  regfile_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_port_a (
    .clk(CLK), .rst_n(RST), .rd_en(RdEn_A), .rd_addr(RdAddr_A),
    .wr_en(WrEn), .wr_addr(WrAddr), .wr_data(WrData), .wr_strb(WrStrb),
    .mem(mem), .rd_data(RdData_A), .rd_valid(RdValid_A)
  );
  regfile_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_port_b (
    .clk(CLK), .rst_n(RST), .rd_en(RdEn_B), .rd_addr(RdAddr_B),
    .wr_en(WrEn), .wr_addr(WrAddr), .wr_data(WrData), .wr_strb(WrStrb),
    .mem(mem), .rd_data(RdData_B), .rd_valid(RdValid_B)
  );
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed and random checks of two regfile_2r1w configurations against an array model
module tb_regfile_2r1w;
  logic CLK = 1'b0;
  logic RST;
  logic we, ea, eb;
  logic [2:0] wa, aa, ab;
  logic [15:0] wd;
  logic [1:0] ws;
  logic [15:0] rda0, rdb0, rda1, rdb1;
  logic rva0, rvb0, rva1, rvb1;
  logic [15:0] m [2][8];
  logic [15:0] xa [2];
  logic [15:0] xb [2];
  int dep [2] = '{8, 6};
  bit zr [2] = '{1'b0, 1'b1};
  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  regfile_2r1w #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .WrEn(we), .WrAddr(wa), .WrData(wd), .WrStrb(ws),
    .RdEn_A(ea), .RdAddr_A(aa), .RdData_A(rda0), .RdValid_A(rva0),
    .RdEn_B(eb), .RdAddr_B(ab), .RdData_B(rdb0), .RdValid_B(rvb0)
  );
  regfile_2r1w #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1'b1)) dut1 (
    .CLK(CLK), .RST(RST), .WrEn(we), .WrAddr(wa), .WrData(wd), .WrStrb(ws),
    .RdEn_A(ea), .RdAddr_A(aa), .RdData_A(rda1), .RdValid_A(rva1),
    .RdEn_B(eb), .RdAddr_B(ab), .RdData_B(rdb1), .RdValid_B(rvb1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int d, input logic [2:0] a);
    return (int'(a) < dep[d]) && !(zr[d] && (a == 3'd0));
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) m[d][k] = 16'h0;
      xa[d] = 16'h0;
      xb[d] = 16'h0;
    end
  endtask

  task automatic chk_all(input string tag, input logic va, input logic vb);
    chk({tag, "_a0"}, rda0, xa[0]);
    chk({tag, "_b0"}, rdb0, xb[0]);
    chk({tag, "_a1"}, rda1, xa[1]);
    chk({tag, "_b1"}, rdb1, xb[1]);
    chk({tag, "_va0"}, 16'(rva0), 16'(va));
    chk({tag, "_vb0"}, 16'(rvb0), 16'(vb));
    chk({tag, "_va1"}, 16'(rva1), 16'(va));
    chk({tag, "_vb1"}, 16'(rvb1), 16'(vb));
  endtask

  task automatic step(input logic w, input logic [2:0] wa_i, input logic [15:0] wd_i, input logic [1:0] ws_i,
                      input logic a_en, input logic [2:0] a_i, input logic b_en, input logic [2:0] b_i,
                      input string tag);
    we = w; wa = wa_i; wd = wd_i; ws = ws_i;
    ea = a_en; aa = a_i; eb = b_en; ab = b_i;
    for (int d = 0; d < 2; d++) begin
      if (w && legal(d, wa_i))
        for (int i = 0; i < 2; i++)
          if (ws_i[i]) m[d][wa_i][8*i +: 8] = wd_i[8*i +: 8];
      if (a_en) xa[d] = legal(d, a_i) ? m[d][a_i] : 16'h0;
      if (b_en) xb[d] = legal(d, b_i) ? m[d][b_i] : 16'h0;
    end
    @(posedge CLK);
    #1;
    chk_all(tag, a_en, b_en);
  endtask

  initial begin
    RST = 1'b1;
    we = 0; wa = 0; wd = 0; ws = 0; ea = 0; aa = 0; eb = 0; ab = 0;
    reset_model();
    #2 RST = 1'b0;
    #1 chk_all("rst", 1'b0, 1'b0);
    ea = 1; aa = 3; eb = 1; ab = 7;
    repeat (2) begin
      @(posedge CLK);
      #1 chk_all("rst_hold", 1'b0, 1'b0);
    end
    @(negedge CLK);
    RST = 1'b1;
    ea = 0; eb = 0;
    step(0, 0, 16'h0, 2'b00, 1, 3, 1, 7, "t1");
    chk("t1_const_a", rda0, 16'h0000);
    chk("t1_const_b", rdb0, 16'h0000);
    step(0, 0, 16'h0, 2'b00, 0, 0, 0, 0, "idle");
    step(1, 5, 16'hA5C3, 2'b11, 0, 0, 0, 0, "t2_w1");
    step(1, 5, 16'h1200, 2'b10, 0, 0, 0, 0, "t2_w2");
    step(0, 0, 16'h0, 2'b00, 1, 5, 1, 5, "t2");
    chk("t2_const_a0", rda0, 16'h12C3);
    chk("t2_const_b0", rdb0, 16'h12C3);
    chk("t2_const_a1", rda1, 16'h12C3);
    step(1, 1, 16'h0001, 2'b11, 0, 0, 0, 0, "t3_w");
    step(1, 2, 16'hBEEF, 2'b11, 1, 2, 1, 1, "t3");
    chk("t3_const_a", rda0, 16'hBEEF);
    chk("t3_const_b", rdb0, 16'h0001);
    step(1, 4, 16'h3344, 2'b11, 0, 0, 0, 0, "t4_w");
    step(1, 4, 16'hFF00, 2'b01, 1, 4, 0, 0, "t4");
    chk("t4_const_byp", rda0, 16'h3300);
    step(0, 0, 16'h0, 2'b00, 1, 4, 1, 4, "t4_rd");
    chk("t4_const_mem", rdb0, 16'h3300);
    step(1, 0, 16'hFFFF, 2'b11, 0, 0, 0, 0, "t5_w0");
    step(0, 0, 16'h0, 2'b00, 1, 0, 1, 0, "t5_r0");
    chk("t5_const_zero", rda1, 16'h0000);
    chk("t5_const_nz", rda0, 16'hFFFF);
    step(1, 6, 16'h7777, 2'b11, 0, 0, 0, 0, "t5_w6");
    step(0, 0, 16'h0, 2'b00, 1, 6, 1, 6, "t5_r6");
    chk("t5_const_oor", rda1, 16'h0000);
    chk("t5_const_in", rda0, 16'h7777);
    for (int a = 0; a < 8; a++) step(0, 0, 16'h0, 2'b00, 1, 3'(a), 1, 3'(7 - a), "scan");
    step(1, 0, 16'h1234, 2'b11, 1, 0, 1, 0, "zero_byp");
    step(1, 3, 16'hABCD, 2'b00, 1, 3, 1, 3, "no_strb");
    step(1, 7, 16'h5A5A, 2'b11, 1, 7, 1, 7, "oor_byp");
    step(1, 5, 16'hC3C3, 2'b01, 1, 5, 1, 5, "same_byp");
    for (int n = 0; n < 400; n++) begin
      logic [2:0] r_wa;
      r_wa = 3'($urandom);
      step(1'($urandom), r_wa, 16'($urandom), 2'($urandom),
           1'($urandom), ($urandom_range(0, 3) == 0) ? r_wa : 3'($urandom),
           1'($urandom), ($urandom_range(0, 3) == 0) ? r_wa : 3'($urandom), "rnd");
    end
    step(1, 5, 16'h12C3, 2'b11, 0, 0, 0, 0, "t6_w");
    we = 0; ea = 1; aa = 5; eb = 0;
    @(posedge CLK);
    #2 RST = 1'b0;
    reset_model();
    #1 chk_all("t6_rst", 1'b0, 1'b0);
    chk("t6_const_a", rda0, 16'h0000);
    @(negedge CLK);
    ea = 0;
    RST = 1'b1;
    step(0, 0, 16'h0, 2'b00, 0, 0, 0, 0, "t6_post");
    step(0, 0, 16'h0, 2'b00, 1, 5, 1, 5, "t6_rd");
    chk("t6_const_rd", rda0, 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
